// File: rtl/hrange_stream.sv
// hrange_stream: signed range() generator with a ready/valid output.
// Emits base, base+step, base+2*step, ... while the value stays strictly on
// the near side of limit. The sign of step selects the direction; a zero
// step gives an empty range. Arithmetic is done one bit wider than WIDTH,
// so a step that would overflow ends the sequence instead of wrapping.
`timescale 1ns/1ps
module hrange_stream #(
  parameter int WIDTH   = 32,
  parameter int INDEX_W = 32
) (
  input  logic                      _clock,
  input  logic                      _reset,
  input  logic                      _start,
  input  logic signed [WIDTH-1:0]   base,
  input  logic signed [WIDTH-1:0]   limit,
  input  logic signed [WIDTH-1:0]   step,
  input  logic                      _output_ready,
  output logic signed [WIDTH-1:0]   _0,
  output logic [INDEX_W-1:0]        _index,
  output logic                      _valid,
  output logic                      _ready,
  output logic                      _busy
);

  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

  localparam logic [INDEX_W-1:0] IDX_ONE = INDEX_W'(1);

  state_t                  state;
  logic signed [WIDTH-1:0] lim_q;
  logic signed [WIDTH-1:0] step_q;

  // Widened operands: one extra sign bit keeps cur+step exact.
  logic signed [WIDTH:0]   cur_ext;
  logic signed [WIDTH:0]   step_q_ext;
  logic signed [WIDTH:0]   lim_q_ext;
  logic signed [WIDTH:0]   next_ext;
  logic signed [WIDTH:0]   base_ext;
  logic signed [WIDTH:0]   limit_ext;
  logic                    base_cont;
  logic                    next_cont;
  logic                    hs;

  // Continuation test: strictly before limit in the direction of step.
  // A zero step never continues, so it cannot produce an endless stream.
  function automatic logic cont(input logic signed [WIDTH:0]   x,
                                input logic signed [WIDTH:0]   lim,
                                input logic signed [WIDTH-1:0] stp);
    logic r;
    r = 1'b0;
    if (stp > 0)      r = (x < lim);
    else if (stp < 0) r = (x > lim);
    return r;
  endfunction

  // Next-value arithmetic and the two continuation decisions (fresh start
  // uses the live inputs, running sequence uses the latched ones).
  always_comb begin
    cur_ext    = {_0[WIDTH-1], _0};
    step_q_ext = {step_q[WIDTH-1], step_q};
    lim_q_ext  = {lim_q[WIDTH-1], lim_q};
    next_ext   = cur_ext + step_q_ext;
    base_ext   = {base[WIDTH-1], base};
    limit_ext  = {limit[WIDTH-1], limit};
    base_cont  = cont(base_ext, limit_ext, step);
    next_cont  = cont(next_ext, lim_q_ext, step_q);
    hs         = _valid && _output_ready;
  end

  // Control FSM with registered outputs. A start in any state wins: it
  // drops any pending element and suppresses the done pulse of the
  // abandoned run. _ready defaults low so it can only ever pulse.
  always_ff @(posedge _clock or posedge _reset) begin
    if (_reset) begin
      state  <= IDLE;
      lim_q  <= '0;
      step_q <= '0;
      _0     <= '0;
      _index <= '0;
      _valid <= 1'b0;
      _ready <= 1'b0;
      _busy  <= 1'b0;
    end else begin
      _ready <= 1'b0;
      if (_start) begin
        lim_q  <= limit;
        step_q <= step;
        _busy  <= 1'b1;
        if (base_cont) begin
          _0     <= base;
          _index <= '0;
          _valid <= 1'b1;
          state  <= EMIT;
        end else begin
          _valid <= 1'b0;
          state  <= DONE;
        end
      end else begin
        case (state)
          IDLE: ;
          EMIT: begin
            if (hs) begin
              if (next_cont) begin
                _0     <= next_ext[WIDTH-1:0];
                _index <= _index + IDX_ONE;
              end else begin
                _valid <= 1'b0;
                state  <= DONE;
              end
            end
          end
          DONE: begin
            _ready <= 1'b1;
            _busy  <= 1'b0;
            state  <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hrange_stream.sv
// Bench for hrange_stream: two instances (32-bit, and 8-bit with a 4-bit
// index so wrap is exercised), directed and random ranges checked against
// a plain arithmetic model of range(), plus backpressure, restart and
// asynchronous reset scenarios.
`timescale 1ns/1ps
module tb_hrange_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic oready;
  logic start32, start8;
  logic signed [31:0] base32, limit32, step32, o32;
  logic [31:0] idx32;
  logic v32, r32, b32;
  logic signed [7:0] base8, limit8, step8, o8;
  logic [3:0] idx8;
  logic v8, r8, b8;

  hrange_stream #(.WIDTH(32), .INDEX_W(32)) u32 (
    ._clock(clk), ._reset(rst), ._start(start32),
    .base(base32), .limit(limit32), .step(step32),
    ._output_ready(oready), ._0(o32), ._index(idx32),
    ._valid(v32), ._ready(r32), ._busy(b32));

  hrange_stream #(.WIDTH(8), .INDEX_W(4)) u8 (
    ._clock(clk), ._reset(rst), ._start(start8),
    .base(base8), .limit(limit8), .step(step8),
    ._output_ready(oready), ._0(o8), ._index(idx8),
    ._valid(v8), ._ready(r8), ._busy(b8));

  int tests = 0;
  int fails = 0;

  bit     sel8;
  longint exp_q[$];
  longint acc_val[$];
  longint acc_idx[$];
  bit     cv[$], cr[$], cb[$];
  int     held_change;
  bit     timeout;

  typedef struct {
    bit     w8;
    longint b;
    longint l;
    longint s;
    int     pct;
  } case_t;

  function automatic longint obs_val();
    return sel8 ? longint'(o8) : longint'(o32);
  endfunction
  function automatic longint obs_idx();
    return sel8 ? longint'({60'd0, idx8}) : longint'({32'd0, idx32});
  endfunction
  function automatic bit obs_valid(); return sel8 ? v8 : v32; endfunction
  function automatic bit obs_ready(); return sel8 ? r8 : r32; endfunction
  function automatic bit obs_busy();  return sel8 ? b8 : b32; endfunction

  // Reference: mathematical range() with unbounded integers. Overflow of
  // the DUT width is implied because any such value lies beyond limit.
  function automatic void build_model(input longint b, input longint l, input longint s);
    longint x;
    exp_q.delete();
    if (s == 0) return;
    x = b;
    while ((s > 0) ? (x < l) : (x > l)) begin
      exp_q.push_back(x);
      x += s;
    end
  endfunction

  // Starts one range and records what the consumer sees, cycle by cycle,
  // until one cycle past the done pulse or the budget runs out.
  task automatic run_range(input bit w8, input longint b, input longint l, input longint s,
                           input int pct, input int hold, input int budget);
    int     wait_cnt;
    bit     pend, seen_r, stop, v;
    longint pv, pi;
    wait_cnt = 0; pend = 0; seen_r = 0; stop = 0; pv = 0; pi = 0;
    sel8 = w8;
    acc_val.delete(); acc_idx.delete(); cv.delete(); cr.delete(); cb.delete();
    held_change = 0;
    timeout = 1;
    @(negedge clk);
    if (w8) begin
      base8 = b[7:0]; limit8 = l[7:0]; step8 = s[7:0]; start8 = 1'b1;
    end else begin
      base32 = b[31:0]; limit32 = l[31:0]; step32 = s[31:0]; start32 = 1'b1;
    end
    oready = 1'b0;
    @(negedge clk);
    start8 = 1'b0; start32 = 1'b0;
    for (int c = 0; c < budget && !stop; c++) begin
      v = obs_valid();
      cv.push_back(v); cr.push_back(obs_ready()); cb.push_back(obs_busy());
      if (pend && (!v || obs_val() != pv || obs_idx() != pi)) held_change++;
      if (v) begin
        if (hold > 0) oready = (wait_cnt >= hold);
        else          oready = ($urandom_range(0, 99) < pct);
      end else begin
        oready = ($urandom_range(0, 1) == 1);
      end
      if (v && oready) begin
        acc_val.push_back(obs_val());
        acc_idx.push_back(obs_idx());
        wait_cnt = 0;
      end else if (v) begin
        wait_cnt++;
      end
      pend = v && !oready;
      pv = obs_val(); pi = obs_idx();
      if (seen_r) begin stop = 1; timeout = 0; end
      if (obs_ready()) seen_r = 1;
      @(negedge clk);
    end
    oready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++;
    if ({o32, idx32, v32, r32, b32} !== '0) begin
      fails++; $display("FAIL reset32: got o=%0d idx=%0d v=%0b r=%0b b=%0b want all 0", o32, idx32, v32, r32, b32);
    end
    tests++;
    if ({o8, idx8, v8, r8, b8} !== '0) begin
      fails++; $display("FAIL reset8: got o=%0d idx=%0d v=%0b r=%0b b=%0b want all 0", o8, idx8, v8, r8, b8);
    end
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if ({v32, r32, b32, v8, r8, b8} !== '0) begin
      fails++; $display("FAIL idle_quiet: got flags %b want 000000", {v32, r32, b32, v8, r8, b8});
    end
  endtask

  task automatic test_ranges();
    case_t cases[$];
    case_t k;
    int n, lv, nr, rc, bad;
    cases.push_back('{0, 0, 5, 2, 100});
    cases.push_back('{0, 10, 0, -3, 100});
    cases.push_back('{0, 5, 5, 1, 100});
    cases.push_back('{0, 0, 9, 0, 100});
    cases.push_back('{1, 120, 127, 5, 100});
    cases.push_back('{1, -120, -128, -5, 100});
    cases.push_back('{0, 64'sd2147483640, 64'sd2147483647, 5, 100});
    cases.push_back('{1, -128, 127, 1, 100});
    for (int r = 0; r < 20; r++) begin
      k.w8  = ($urandom_range(0, 1) == 1);
      k.pct = (r % 3 == 0) ? 100 : int'($urandom_range(50, 100));
      if (k.w8) begin
        k.b = longint'($urandom_range(0, 255)) - 128;
        k.l = longint'($urandom_range(0, 255)) - 128;
        k.s = longint'($urandom_range(0, 80)) - 40;
      end else if (r % 4 == 1) begin
        k.b = 64'sd2147483647 - longint'($urandom_range(0, 40));
        k.l = 64'sd2147483647;
        k.s = longint'($urandom_range(1, 20));
      end else begin
        k.b = longint'($urandom_range(0, 200)) - 100;
        k.l = longint'($urandom_range(0, 200)) - 100;
        k.s = longint'($urandom_range(0, 14)) - 7;
      end
      cases.push_back(k);
    end

    foreach (cases[ci]) begin
      k = cases[ci];
      build_model(k.b, k.l, k.s);
      n = exp_q.size();
      run_range(k.w8, k.b, k.l, k.s, k.pct, 0, (n + 4) * 8 + 40);

      tests++;
      if (timeout) begin
        fails++; $display("FAIL case%0d done_timeout: got no _ready within budget want pulse", ci);
      end
      tests++;
      if (acc_val.size() != n) begin
        fails++; $display("FAIL case%0d count: got %0d elements want %0d (b=%0d l=%0d s=%0d w8=%0b)",
                          ci, acc_val.size(), n, k.b, k.l, k.s, k.w8);
      end
      for (int i = 0; i < n && i < acc_val.size(); i++) begin
        tests++;
        if (acc_val[i] != exp_q[i] || acc_idx[i] != (k.w8 ? longint'(i % 16) : longint'(i))) begin
          fails++; $display("FAIL case%0d elem%0d: got val=%0d idx=%0d want val=%0d idx=%0d",
                            ci, i, acc_val[i], acc_idx[i], exp_q[i], k.w8 ? (i % 16) : i);
        end
      end
      tests++;
      if (held_change != 0) begin
        fails++; $display("FAIL case%0d hold_stable: got %0d changes while stalled want 0", ci, held_change);
      end
      tests++;
      if (cv.size() == 0 || cv[0] != (n > 0)) begin
        fails++; $display("FAIL case%0d first_valid: got %0b want %0b", ci, (cv.size() > 0) ? cv[0] : 1'b0, n > 0);
      end
      lv = -1; nr = 0; rc = -1;
      foreach (cv[c]) if (cv[c]) lv = c;
      foreach (cr[c]) if (cr[c]) begin nr++; if (rc < 0) rc = c; end
      tests++;
      if (nr != 1 || rc != lv + 2) begin
        fails++; $display("FAIL case%0d ready_pulse: got %0d pulses at cycle %0d want 1 at %0d", ci, nr, rc, lv + 2);
      end
      if (k.pct == 100) begin
        tests++;
        if (rc != n + 1) begin
          fails++; $display("FAIL case%0d throughput: got ready at cycle %0d want %0d", ci, rc, n + 1);
        end
      end
      if (rc >= 0) begin
        bad = 0;
        foreach (cb[c]) if (cb[c] != (c < rc)) bad++;
        tests++;
        if (bad != 0) begin
          fails++; $display("FAIL case%0d busy: got %0d wrong cycles want 0", ci, bad);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int nvalid, nr;
    run_range(0, 1, 4, 1, 100, 3, 200);
    tests++;
    if (timeout || acc_val.size() != 3) begin
      fails++; $display("FAIL bp_count: got %0d handshakes timeout=%0b want 3", acc_val.size(), timeout);
    end
    for (int i = 0; i < 3 && i < acc_val.size(); i++) begin
      tests++;
      if (acc_val[i] != longint'(i + 1) || acc_idx[i] != longint'(i)) begin
        fails++; $display("FAIL bp_elem%0d: got val=%0d idx=%0d want val=%0d idx=%0d", i, acc_val[i], acc_idx[i], i + 1, i);
      end
    end
    tests++;
    if (held_change != 0) begin
      fails++; $display("FAIL bp_stable: got %0d changes while stalled want 0", held_change);
    end
    nvalid = 0; nr = 0;
    foreach (cv[c]) if (cv[c]) nvalid++;
    foreach (cr[c]) if (cr[c]) nr++;
    tests++;
    if (nvalid != 12 || nr != 1) begin
      fails++; $display("FAIL bp_timing: got %0d valid cycles %0d ready pulses want 12 and 1", nvalid, nr);
    end
  endtask

  task automatic test_restart();
    int nr, bad, e, got;
    sel8 = 0;
    @(negedge clk);
    base32 = 0; limit32 = 10; step32 = 1; start32 = 1'b1; oready = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    nr = 0; bad = 0;
    for (int k = 0; k < 3; k++) begin
      if (!v32 || o32 != k) bad++;
      if (r32) nr++;
      @(negedge clk);
    end
    tests++;
    if (bad != 0 || !v32 || o32 != 3 || idx32 != 3) begin
      fails++; $display("FAIL restart_pre: got v=%0b o=%0d idx=%0d bad=%0d want v=1 o=3 idx=3 bad=0", v32, o32, idx32, bad);
    end
    base32 = 100; limit32 = 200; step32 = 1; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    base32 = -5; limit32 = 7; step32 = 3;
    tests++;
    if (!v32 || o32 != 100 || idx32 != 0 || r32) begin
      fails++; $display("FAIL restart_first: got v=%0b o=%0d idx=%0d r=%0b want v=1 o=100 idx=0 r=0", v32, o32, idx32, r32);
    end
    e = 100; got = 0; bad = 0;
    for (int c = 0; c < 130; c++) begin
      if (r32) nr++;
      if (v32) begin
        if (o32 != e || idx32 != 32'(e - 100)) bad++;
        e++; got++;
      end
      @(negedge clk);
    end
    tests++;
    if (bad != 0 || got != 100) begin
      fails++; $display("FAIL restart_seq: got %0d elements %0d wrong want 100 and 0", got, bad);
    end
    tests++;
    if (nr != 1) begin
      fails++; $display("FAIL restart_ready: got %0d pulses want 1", nr);
    end
    oready = 1'b0;
  endtask

  task automatic test_async_reset();
    sel8 = 0;
    @(negedge clk);
    base32 = 0; limit32 = 50; step32 = 1; start32 = 1'b1; oready = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (!v32 || o32 != 3) begin
      fails++; $display("FAIL areset_pre: got v=%0b o=%0d want v=1 o=3", v32, o32);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({o32, idx32, v32, r32, b32} !== '0) begin
      fails++; $display("FAIL areset_now: got o=%0d idx=%0d v=%0b r=%0b b=%0b want all 0", o32, idx32, v32, r32, b32);
    end
    start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    tests++;
    if ({v32, b32} !== 2'b00) begin
      fails++; $display("FAIL areset_hold: got v=%0b b=%0b want 0 0", v32, b32);
    end
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if ({v32, r32, b32} !== 3'b000) begin
      fails++; $display("FAIL areset_after: got v=%0b r=%0b b=%0b want 0 0 0", v32, r32, b32);
    end
    oready = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; oready = 1'b0; sel8 = 0;
    start32 = 1'b0; base32 = '0; limit32 = '0; step32 = '0;
    start8 = 1'b0;  base8 = '0;  limit8 = '0;  step8 = '0;
    test_reset();
    test_ranges();
    test_backpressure();
    test_restart();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
